// File: rtl/x_top_uart_cmd.sv
// rtl/x_top_uart_cmd.sv - UART byte-command decoder driving a single 32-bit bus request
module x_top_uart_cmd #(
    parameter int p_timeout = 100000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_accept,
    output logic        o_bus_valid,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata,
    output logic        o_err
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(p_timeout - 1);

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [31:0] idle_cnt;
    logic [31:0] rdata;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            byte_cnt    <= 2'd0;
            idle_cnt    <= 32'd0;
            rdata       <= 32'd0;
            o_bus_addr  <= 32'd0;
            o_bus_wdata <= 32'd0;
            o_bus_valid <= 1'b0;
            o_bus_we    <= 1'b0;
            o_tx_valid  <= 1'b0;
            o_tx_data   <= 8'h00;
            o_err       <= 1'b0;
        end else begin
            o_err <= 1'b0;
            case (state)
                IDLE: begin
                    idle_cnt <= 32'd0;
                    if (i_rx_valid) begin
                        if (i_rx_data == 8'h57 || i_rx_data == 8'h52) begin
                            o_bus_we <= (i_rx_data == 8'h57);
                            byte_cnt <= 2'd0;
                            state    <= ADDR;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                ADDR, DATA: begin
                    // A strobe landing on the timeout cycle wins over the timeout
                    if (i_rx_valid) begin
                        idle_cnt <= 32'd0;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (state == ADDR)
                            o_bus_addr <= {o_bus_addr[23:0], i_rx_data};
                        else
                            o_bus_wdata <= {o_bus_wdata[23:0], i_rx_data};
                        if (byte_cnt == 2'd3) begin
                            if (state == ADDR && o_bus_we) begin
                                state <= DATA;
                            end else begin
                                state       <= BUS;
                                o_bus_valid <= 1'b1;
                            end
                        end
                    end else if (idle_cnt == TIMEOUT_LAST) begin
                        o_err    <= 1'b1;
                        idle_cnt <= 32'd0;
                        state    <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
                end
                BUS: begin
                    idle_cnt <= 32'd0;
                    if (i_rx_valid)
                        o_err <= 1'b1;
                    if (i_bus_ready) begin
                        rdata       <= i_bus_rdata;
                        o_bus_valid <= 1'b0;
                        o_tx_valid  <= 1'b1;
                        o_tx_data   <= o_bus_we ? 8'h4B : i_bus_rdata[31:24];
                        byte_cnt    <= 2'd0;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    idle_cnt <= 32'd0;
                    if (i_rx_valid)
                        o_err <= 1'b1;
                    if (i_tx_accept) begin
                        if (o_bus_we || byte_cnt == 2'd3) begin
                            o_tx_valid <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            byte_cnt  <= byte_cnt + 2'd1;
                            o_tx_data <= rdata[23:16];
                            rdata     <= {rdata[23:0], 8'h00};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_x_top_uart_cmd.sv
// tb/tb_x_top_uart_cmd.sv - scoreboard bench for x_top_uart_cmd
module tb_x_top_uart_cmd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_accept = 1'b0;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = 32'd0;
    logic        err;

    always #5 clk = ~clk;

    x_top_uart_cmd #(.p_timeout(50)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .o_tx_valid(tx_valid), .o_tx_data(tx_data), .i_tx_accept(tx_accept),
        .o_bus_valid(bus_valid), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
        .o_bus_wdata(bus_wdata), .i_bus_ready(bus_ready), .i_bus_rdata(bus_rdata),
        .o_err(err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

    bus_req_t   bus_q[$];
    logic [7:0] tx_q[$];
    int         err_log[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_rx_cyc = 0;
    int stall_target = 0;
    int stall_cnt = 0;
    int accept_mode = 0;
    int last_bus_len = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Bus and transmitter responders
    always @(posedge clk) begin
        #1;
        if (bus_valid) begin
            if (stall_cnt >= stall_target) bus_ready = 1'b1;
            else begin
                bus_ready = 1'b0;
                stall_cnt++;
            end
        end else begin
            bus_ready = 1'b0;
            stall_cnt = 0;
        end
        tx_accept = (accept_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end

    // Bus monitor
    int          bus_hi = 0;
    logic        h_we;
    logic [31:0] h_addr, h_wdata;
    always @(negedge clk) begin
        bus_req_t e;
        if (!rst && bus_valid) begin
            if (bus_hi == 0) begin
                h_we = bus_we; h_addr = bus_addr; h_wdata = bus_wdata;
            end else begin
                chk("bus_we_hold", bus_we, h_we);
                chk("bus_addr_hold", bus_addr, h_addr);
                chk("bus_wdata_hold", bus_wdata, h_wdata);
            end
            bus_hi++;
            if (bus_ready) begin
                if (bus_q.size() == 0) chk("bus_unexpected", bus_valid, 1'b0);
                else begin
                    e = bus_q.pop_front();
                    chk("bus_we", bus_we, e.we);
                    chk("bus_addr", bus_addr, e.addr);
                    if (e.we) chk("bus_wdata", bus_wdata, e.wdata);
                end
                last_bus_len = bus_hi;
                bus_hi = 0;
            end
        end else bus_hi = 0;
    end

    // Transmit monitor
    logic       prev_tx_pend = 1'b0;
    logic [7:0] prev_tx_data = 8'h00;
    always @(negedge clk) begin
        if (prev_tx_pend) begin
            chk("tx_hold_valid", tx_valid, 1'b1);
            chk("tx_hold_data", tx_data, prev_tx_data);
        end
        if (tx_valid && tx_accept) begin
            if (tx_q.size() == 0) chk("tx_unexpected", tx_valid, 1'b0);
            else chk("tx_byte", tx_data, tx_q.pop_front());
        end
        prev_tx_pend = tx_valid && !tx_accept && !rst;
        prev_tx_data = tx_data;
    end

    // Error strobe monitor
    logic prev_err = 1'b0;
    always @(negedge clk) begin
        if (err) begin
            err_log.push_back(cyc);
            chk("err_single_cycle", prev_err, 1'b0);
        end
        prev_err = err;
    end

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        last_rx_cyc = cyc;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((bus_q.size() != 0 || tx_q.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, bus_q.size() + tx_q.size(), 0);
        chk({name, "_tx_low"}, tx_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic push_read(input logic [31:0] a, input logic [31:0] rd);
        bus_req_t r;
        r.we = 1'b0; r.addr = a; r.wdata = 32'd0;
        bus_q.push_back(r);
        bus_rdata = rd;
        tx_q.push_back(rd[31:24]); tx_q.push_back(rd[23:16]);
        tx_q.push_back(rd[15:8]);  tx_q.push_back(rd[7:0]);
    endtask

    task automatic push_write(input logic [31:0] a, input logic [31:0] wd);
        bus_req_t r;
        r.we = 1'b1; r.addr = a; r.wdata = wd;
        bus_q.push_back(r);
        tx_q.push_back(8'h4B);
    endtask

    task automatic check_outputs_zero(input string name);
        chk({name, "_tx_valid"}, tx_valid, 1'b0);
        chk({name, "_tx_data"}, tx_data, 8'h00);
        chk({name, "_bus_valid"}, bus_valid, 1'b0);
        chk({name, "_bus_we"}, bus_we, 1'b0);
        chk({name, "_err"}, err, 1'b0);
        chk({name, "_bus_addr"}, bus_addr, 32'd0);
        chk({name, "_bus_wdata"}, bus_wdata, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int n;
        logic [7:0] gap_bytes [4];

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // Write, bus ready immediately
        stall_target = 0; accept_mode = 0;
        push_write(32'h0000_1004, 32'hDEAD_BEEF);
        send(8'h57); send(8'h00); send(8'h00); send(8'h10); send(8'h04);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        chk("bus_valid_rise", bus_valid, 1'b1);
        wait_drain("write");
        chk("write_bus_len", last_bus_len, 1);

        // Read with a 5-cycle bus stall and slow transmitter
        stall_target = 5; accept_mode = 1;
        push_read(32'h0000_0020, 32'h1234_5678);
        send(8'h52); send(8'h00); send(8'h00); send(8'h00); send(8'h20);
        wait_drain("read_stall");
        chk("read_bus_len", last_bus_len, 6);

        // Overrun during the response
        stall_target = 0; accept_mode = 1;
        n0 = err_log.size();
        push_read(32'h0000_0040, 32'hA1B2_C3D4);
        send(8'h52); send(8'h00); send(8'h00); send(8'h00); send(8'h40);
        n = 0;
        while (!tx_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("overrun_resp_reached", tx_valid, 1'b1);
        send(8'h99);
        wait_drain("overrun");
        chk("overrun_err", err_log.size(), n0 + 1);

        // Bad opcode, then a normal read
        accept_mode = 0;
        n0 = err_log.size();
        send(8'h41);
        repeat (5) @(posedge clk);
        #1;
        chk("badop_err", err_log.size(), n0 + 1);
        chk("badop_no_bus", bus_valid, 1'b0);
        chk("badop_no_tx", tx_valid, 1'b0);
        push_read(32'h0000_0030, 32'hCAFE_F00D);
        send(8'h52); send(8'h00); send(8'h00); send(8'h00); send(8'h30);
        wait_drain("badop_read");

        // Timeout after a partial command
        n0 = err_log.size();
        send(8'h52); send(8'h00); send(8'h00);
        repeat (60) @(posedge clk);
        #1;
        chk("timeout_err", err_log.size(), n0 + 1);
        if (err_log.size() > n0) chk("timeout_delay", err_log[n0] - last_rx_cyc, 50);
        send(8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("timeout_then_badop", err_log.size(), n0 + 2);

        // Strobe on the exact timeout cycle is accepted
        n0 = err_log.size();
        push_read(32'h0000_0050, 32'h0BAD_F00D);
        gap_bytes[0] = 8'h00; gap_bytes[1] = 8'h00; gap_bytes[2] = 8'h00; gap_bytes[3] = 8'h50;
        send(8'h52);
        for (int i = 0; i < 4; i++) begin
            repeat (49) @(posedge clk);
            #1;
            send(gap_bytes[i]);
        end
        wait_drain("edge_timeout");
        chk("edge_timeout_no_err", err_log.size(), n0);

        // Reset in the middle of the data phase
        n0 = err_log.size();
        send(8'h57); send(8'h00); send(8'h00); send(8'h00); send(8'h00); send(8'hAA);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs_zero("mid_reset");
        rst = 1'b0;
        push_write(32'h0000_0008, 32'h1122_3344);
        send(8'h57); send(8'h00); send(8'h00); send(8'h00); send(8'h08);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        wait_drain("after_reset");
        chk("after_reset_no_err", err_log.size(), n0);

        chk("bus_q_empty", bus_q.size(), 0);
        chk("tx_q_empty", tx_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
